// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the mux channel scanner.
// Channel count, select width, FSM states and lowest-channel search.
package mux_scan_pkg;

   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   // Lowest set bit of the mask as a channel index; 0 for an empty mask.
   function automatic logic [SEL_W-1:0] first_enabled(
      input logic [NUM_CH-1:0] mask
   );
      logic [SEL_W-1:0] ch;
      ch = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask[i]) ch = SEL_W'(i);
      end
      return ch;
   endfunction

endpackage

// File: rtl/mux_scan_next_ch.sv
// Next-channel lookup for the scanner.
// Finds the next enabled channel above cur, wrapping to the lowest one.
module mux_scan_next_ch
   import mux_scan_pkg::*;
(
   input  logic [SEL_W-1:0]  cur,
   input  logic [NUM_CH-1:0] mask,
   output logic [SEL_W-1:0]  next,
   output logic              last
);

   // Scan downward so the nearest enabled channel above cur wins.
   always_comb begin
      next = first_enabled(mask);
      last = 1'b1;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask[i] && (i > int'(cur))) begin
            next = SEL_W'(i);
            last = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mux_channel_scanner.sv
// Steps a 4:1 mux through enabled channels and samples its output.
// Publishes one 4-bit frame per pass with a single-cycle valid strobe.
module mux_channel_scanner
   import mux_scan_pkg::*;
#(
   parameter int unsigned DWELL  = 4,
   parameter int unsigned SETTLE = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              continuous,
   input  logic [NUM_CH-1:0] channel_mask,
   input  logic              mux_out,
   output logic [SEL_W-1:0]  select,
   output logic [NUM_CH-1:0] sample,
   output logic              frame_valid,
   output logic              busy
);

   localparam logic [7:0] LAST_CNT   = 8'(DWELL - 1);
   localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

   state_t            state, state_n;
   logic [7:0]        cnt, cnt_n;
   logic [NUM_CH-1:0] shadow, shadow_n, shadow_cap;
   logic [NUM_CH-1:0] mask_q, mask_n;
   logic              cont_q, cont_n;
   logic [SEL_W-1:0]  sel_n;
   logic [NUM_CH-1:0] sample_n;
   logic              fv_n, busy_n;
   logic [SEL_W-1:0]  nxt_ch;
   logic              last_ch;
   logic              dwell_end, frame_end;

   mux_scan_next_ch u_next (
      .cur  (select),
      .mask (mask_q),
      .next (nxt_ch),
      .last (last_ch)
   );

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         shadow      <= '0;
         mask_q      <= '0;
         cont_q      <= 1'b0;
         select      <= '0;
         sample      <= '0;
         frame_valid <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         shadow      <= shadow_n;
         mask_q      <= mask_n;
         cont_q      <= cont_n;
         select      <= sel_n;
         sample      <= sample_n;
         frame_valid <= fv_n;
         busy        <= busy_n;
      end
   end

   // Next-state logic; the capture is folded into shadow_cap so a
   // capture on the frame-end edge still lands in the published word.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      shadow_n   = shadow;
      mask_n     = mask_q;
      cont_n     = cont_q;
      sel_n      = select;
      sample_n   = sample;
      fv_n       = 1'b0;
      busy_n     = busy;
      shadow_cap = shadow;
      if (state == SCAN && cnt == SETTLE_CNT) shadow_cap[select] = mux_out;
      dwell_end = (cnt == LAST_CNT);
      frame_end = (state == SCAN) && dwell_end && last_ch;

      unique case (state)
         IDLE: begin
            if (start && !stop && (|channel_mask)) begin
               state_n  = SCAN;
               mask_n   = channel_mask;
               cont_n   = continuous;
               sel_n    = first_enabled(channel_mask);
               cnt_n    = '0;
               shadow_n = '0;
               busy_n   = 1'b1;
            end
         end
         SCAN: begin
            shadow_n = shadow_cap;
            cnt_n    = cnt + 8'd1;
            if (dwell_end) begin
               cnt_n = '0;
               sel_n = nxt_ch;
            end
            if (frame_end) begin
               sample_n = shadow_cap & mask_q;
               fv_n     = 1'b1;
               if (cont_q && !stop) begin
                  sel_n    = first_enabled(mask_q);
                  shadow_n = '0;
               end else begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
                  sel_n   = '0;
                  cnt_n   = '0;
               end
            end else if (stop) begin
               state_n = IDLE;
               busy_n  = 1'b0;
               sel_n   = '0;
               cnt_n   = '0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Directed bench for mux_channel_scanner with a behavioural 4:1 mux.
// DWELL=4, SETTLE=1; inputs driven and outputs sampled 1ns after the edge.
module tb_mux_channel_scanner;

   logic       clk;
   logic       reset;
   logic       start;
   logic       stop;
   logic       continuous;
   logic [3:0] channel_mask;
   logic       mux_out;
   logic [1:0] select;
   logic [3:0] sample;
   logic       frame_valid;
   logic       busy;
   logic [3:0] in_vec;

   int checks;
   int errors;

   mux_channel_scanner #(.DWELL(4), .SETTLE(1)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .stop         (stop),
      .continuous   (continuous),
      .channel_mask (channel_mask),
      .mux_out      (mux_out),
      .select       (select),
      .sample       (sample),
      .frame_valid  (frame_valid),
      .busy         (busy)
   );

   assign mux_out = in_vec[select];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one edge; returns just after that edge.
   task automatic start_scan(input logic [3:0] m, input logic c);
      channel_mask = m;
      continuous   = c;
      start        = 1'b1;
      tick();
      start        = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      stop  = 1'b0;
      continuous   = 1'b0;
      channel_mask = 4'b0000;
      in_vec       = 4'b0000;
      repeat (3) tick();
      checks++;
      if ({select, sample, frame_valid, busy} !== 8'h00) begin
         errors++;
         $display("FAIL reset: sel=%0d sample=%b fv=%b busy=%b, want all 0",
                  select, sample, frame_valid, busy);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_full_scan();
      in_vec = 4'b1010;
      start_scan(4'b1111, 1'b0);
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (select !== 2'(k / 4) || frame_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL full_scan k=%0d: sel=%0d fv=%b busy=%b, want sel=%0d fv=0 busy=1",
                     k, select, frame_valid, busy, k / 4);
         end
         tick();
      end
      checks++;
      if (frame_valid !== 1'b1 || sample !== 4'b1010 || busy !== 1'b0 || select !== 2'd0) begin
         errors++;
         $display("FAIL full_scan end: fv=%b sample=%b busy=%b sel=%0d, want 1 1010 0 0",
                  frame_valid, sample, busy, select);
      end
      tick();
      checks++;
      if (frame_valid !== 1'b0) begin
         errors++;
         $display("FAIL full_scan pulse width: fv=%b, want 0", frame_valid);
      end
   endtask

   task automatic test_masked_scan();
      in_vec = 4'b0111;
      start_scan(4'b0101, 1'b0);
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (select !== ((k < 4) ? 2'd0 : 2'd2) || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL masked k=%0d: sel=%0d fv=%b, want sel=%0d fv=0",
                     k, select, frame_valid, (k < 4) ? 0 : 2);
         end
         tick();
      end
      checks++;
      if (frame_valid !== 1'b1 || sample !== 4'b0101 || busy !== 1'b0) begin
         errors++;
         $display("FAIL masked end: fv=%b sample=%b busy=%b, want 1 0101 0",
                  frame_valid, sample, busy);
      end
      tick();
   endtask

   task automatic test_continuous();
      in_vec = 4'b0011;
      start_scan(4'b1111, 1'b1);
      repeat (16) tick();
      checks++;
      if (frame_valid !== 1'b1 || sample !== 4'b0011 || busy !== 1'b1 || select !== 2'd0) begin
         errors++;
         $display("FAIL cont frame1: fv=%b sample=%b busy=%b sel=%0d, want 1 0011 1 0",
                  frame_valid, sample, busy, select);
      end
      in_vec = 4'b1100;
      for (int k = 1; k < 16; k++) begin
         tick();
         checks++;
         if (frame_valid !== 1'b0 || select !== 2'(k / 4) || busy !== 1'b1) begin
            errors++;
            $display("FAIL cont gap k=%0d: fv=%b sel=%0d busy=%b, want 0 %0d 1",
                     k, frame_valid, select, busy, k / 4);
         end
      end
      tick();
      checks++;
      if (frame_valid !== 1'b1 || sample !== 4'b1100) begin
         errors++;
         $display("FAIL cont frame2: fv=%b sample=%b, want 1 1100",
                  frame_valid, sample);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++;
      if (busy !== 1'b0 || frame_valid !== 1'b0 || select !== 2'd0) begin
         errors++;
         $display("FAIL cont stop: busy=%b fv=%b sel=%0d, want 0 0 0",
                  busy, frame_valid, select);
      end
   endtask

   task automatic test_stop();
      in_vec = 4'b0101;
      start_scan(4'b1111, 1'b0);
      repeat (6) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++;
      if (busy !== 1'b0 || select !== 2'd0 || frame_valid !== 1'b0 || sample !== 4'b1100) begin
         errors++;
         $display("FAIL stop: busy=%b sel=%0d fv=%b sample=%b, want 0 0 0 1100",
                  busy, select, frame_valid, sample);
      end
      for (int k = 0; k < 20; k++) begin
         tick();
         checks++;
         if (frame_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop idle k=%0d: fv=%b busy=%b, want 0 0",
                     k, frame_valid, busy);
         end
      end
   endtask

   task automatic test_ignored_starts();
      start_scan(4'b0000, 1'b0);
      checks++;
      if (busy !== 1'b0 || select !== 2'd0) begin
         errors++;
         $display("FAIL zero mask start: busy=%b sel=%0d, want 0 0", busy, select);
      end
      stop = 1'b1;
      start_scan(4'b1111, 1'b0);
      stop = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL start+stop: busy=%b, want 0", busy);
      end
      tick();
      in_vec = 4'b1111;
      start_scan(4'b1111, 1'b0);
      repeat (5) tick();
      start_scan(4'b0001, 1'b1);
      for (int k = 6; k < 16; k++) begin
         checks++;
         if (frame_valid !== 1'b0 || select !== 2'(k / 4)) begin
            errors++;
            $display("FAIL busy start k=%0d: fv=%b sel=%0d, want 0 %0d",
                     k, frame_valid, select, k / 4);
         end
         tick();
      end
      checks++;
      if (frame_valid !== 1'b1 || sample !== 4'b1111 || busy !== 1'b0) begin
         errors++;
         $display("FAIL busy start end: fv=%b sample=%b busy=%b, want 1 1111 0",
                  frame_valid, sample, busy);
      end
      tick();
   endtask

   task automatic test_reset_mid_scan();
      in_vec = 4'b0110;
      start_scan(4'b1111, 1'b0);
      repeat (10) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (select !== 2'd0 || sample !== 4'b0000 || busy !== 1'b0 || frame_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset mid: sel=%0d sample=%b busy=%b fv=%b, want 0 0000 0 0",
                  select, sample, busy, frame_valid);
      end
      in_vec = 4'b1000;
      start_scan(4'b1000, 1'b0);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (select !== 2'd3 || frame_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL after reset k=%0d: sel=%0d fv=%b busy=%b, want 3 0 1",
                     k, select, frame_valid, busy);
         end
         tick();
      end
      checks++;
      if (frame_valid !== 1'b1 || sample !== 4'b1000 || busy !== 1'b0) begin
         errors++;
         $display("FAIL after reset end: fv=%b sample=%b busy=%b, want 1 1000 0",
                  frame_valid, sample, busy);
      end
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_full_scan();
      test_masked_scan();
      test_continuous();
      test_stop();
      test_ignored_starts();
      test_reset_mid_scan();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
